pic_priority_arbiter: RTL and testbench

//  Clocked interrupt scheduler for the 8259 PIC. It latches IR0-IR7 into the IRR, masks them with
//  the IMR, and resolves priority against the ISR (fully nested, with rotation). It drives INT and

---
 rtl/pic_pkg.sv | 23 ++
 rtl/pic_prio_encoder.sv | 33 +++
 rtl/pic_priority_arbiter.sv | 176 +++++++++++++++++
 tb/tb_pic_priority_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and OCW2 command encodings for the 8259-style priority arbiter.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2
    } state_t;

    // OCW2 {R, SL, EOI} command codes
    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] EOI_NS       = 3'b001;
    localparam logic [2:0] OCW2_NOP     = 3'b010;
    localparam logic [2:0] EOI_SP       = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NS       = 3'b101;
    localparam logic [2:0] SET_PR       = 3'b110;
    localparam logic [2:0] ROT_SP       = 3'b111;

    localparam logic [2:0] SPURIOUS_IDX = 3'd7;
    localparam logic [2:0] LP_RESET     = 3'd7;

endpackage

// File: rtl/pic_prio_encoder.sv
// Rotating priority encoder: finds the set bit of vec_i with the best rank,
// where rank(i) = (i - lp_i - 1) mod NUM_IRQ and rank 0 wins.
module pic_prio_encoder #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_IRQ-1:0] vec_i,
    input  logic [IDX_W-1:0]   lp_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               hit_o,
    output logic [IDX_W-1:0]   rank_o
);

    logic [IDX_W-1:0] pos;

    // Walk from worst rank to best so the best-ranked hit is written last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx_o  = '0;
        hit_o  = 1'b0;
        rank_o = '0;
        pos    = '0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            pos = lp_i + IDX_W'(r) + IDX_W'(1);
            if (vec_i[pos]) begin
                idx_o  = pos;
                hit_o  = 1'b1;
                rank_o = IDX_W'(r);
            end
        end
    end

endmodule

// File: rtl/pic_priority_arbiter.sv
// 8259 interrupt scheduler: IRR/ISR, rotating priority, INT and two-pulse INTA sequencing.
// Optional macro PIC_SPECIAL_MASK_EN adds the smm input (special mask mode).
module pic_priority_arbiter
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PIC_SPECIAL_MASK_EN
    input  logic               smm,
`endif
    input  logic [NUM_IRQ-1:0] ir,
    input  logic               ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               aeoi,
    input  logic               eoi_stb,
    input  logic [2:0]         eoi_cmd,
    input  logic [IDX_W-1:0]   eoi_lvl,
    input  logic               inta_p1,
    input  logic               inta_p2,
    output logic               int_out,
    output logic [IDX_W-1:0]   vec_idx,
    output logic               vec_vld,
    output logic [NUM_IRQ-1:0] irr_q,
    output logic [NUM_IRQ-1:0] isr_q
);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] ir_q;
    logic [NUM_IRQ-1:0] irr_d, isr_d;
    logic [IDX_W-1:0]   lp_q, lp_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               spur_q, spur_d;
    logic               rot_aeoi_q, rot_aeoi_d;
    logic               int_q, int_d;
    logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
    logic               vec_vld_q, vec_vld_d;

    logic [NUM_IRQ-1:0] isr_cmp;
    logic [IDX_W-1:0]   irr_idx, irr_rank, isr_idx, isr_rank;
    logic               irr_hit, isr_hit, eligible;

`ifdef PIC_SPECIAL_MASK_EN
    assign isr_cmp = smm ? (isr_q & ~imr) : isr_q;
`else
    assign isr_cmp = isr_q;
`endif

    pic_prio_encoder #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_irr_enc (
        .vec_i  (irr_q & ~imr),
        .lp_i   (lp_q),
        .idx_o  (irr_idx),
        .hit_o  (irr_hit),
        .rank_o (irr_rank)
    );

    pic_prio_encoder #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr_enc (
        .vec_i  (isr_cmp),
        .lp_i   (lp_q),
        .idx_o  (isr_idx),
        .hit_o  (isr_hit),
        .rank_o (isr_rank)
    );

    assign eligible = irr_hit && (!isr_hit || (irr_rank < isr_rank));

    always_comb begin
        state_d    = state_q;
        lp_d       = lp_q;
        gnt_d      = gnt_q;
        spur_d     = spur_q;
        rot_aeoi_d = rot_aeoi_q;
        int_d      = int_q;
        vec_idx_d  = vec_idx_q;
        vec_vld_d  = 1'b0;
        isr_d      = isr_q;

        // Level mode follows ir; edge mode sets on a rising ir and holds until ir drops.
        irr_d = ltim ? ir : ((irr_q | (ir & ~ir_q)) & ir);

        if (eoi_stb) begin
            case (eoi_cmd)
                EOI_NS:       if (isr_hit) isr_d[isr_idx] = 1'b0;
                EOI_SP:       isr_d[eoi_lvl] = 1'b0;
                ROT_NS: begin
                    if (isr_hit) begin
                        isr_d[isr_idx] = 1'b0;
                        lp_d           = isr_idx;
                    end
                end
                ROT_SP: begin
                    if (|isr_q) begin
                        isr_d[eoi_lvl] = 1'b0;
                        lp_d           = eoi_lvl;
                    end
                end
                SET_PR:       lp_d = eoi_lvl;
                ROT_AEOI_SET: rot_aeoi_d = 1'b1;
                ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
                OCW2_NOP:     ;
                default:      ;
            endcase
        end

        // Grant set and AEOI clear come after the EOI clear so a fresh grant survives.
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                if (inta_p1) begin
                    state_d = ACK1;
                    int_d   = 1'b0;
                    if (eligible) begin
                        gnt_d          = irr_idx;
                        spur_d         = 1'b0;
                        isr_d[irr_idx] = 1'b1;
                        irr_d[irr_idx] = 1'b0;
                    end else begin
                        gnt_d  = SPURIOUS_IDX;
                        spur_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_p2) begin
                    state_d   = IDLE;
                    vec_idx_d = gnt_q;
                    vec_vld_d = 1'b1;
                    if (aeoi && !spur_q) isr_d[gnt_q] = 1'b0;
                    if (aeoi && rot_aeoi_q) lp_d = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            irr_q      <= '0;
            isr_q      <= '0;
            lp_q       <= LP_RESET;
            gnt_q      <= '0;
            spur_q     <= 1'b0;
            rot_aeoi_q <= 1'b0;
            int_q      <= 1'b0;
            vec_idx_q  <= '0;
            vec_vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            ir_q       <= ir;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            lp_q       <= lp_d;
            gnt_q      <= gnt_d;
            spur_q     <= spur_d;
            rot_aeoi_q <= rot_aeoi_d;
            int_q      <= int_d;
            vec_idx_q  <= vec_idx_d;
            vec_vld_q  <= vec_vld_d;
        end
    end

    assign int_out = int_q;
    assign vec_idx = vec_idx_q;
    assign vec_vld = vec_vld_q;

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// Scoreboard bench for pic_priority_arbiter: directed scenarios then randomized traffic
// against a rank-arithmetic reference model.
module tb_pic_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir_r = '0;
    logic       ltim_r = 1'b0;
    logic [7:0] imr_r = '0;
    logic       aeoi_r = 1'b0;
    logic       eoi_stb_r = 1'b0;
    logic [2:0] eoi_cmd_r = '0;
    logic [2:0] eoi_lvl_r = '0;
    logic       p1_r = 1'b0;
    logic       p2_r = 1'b0;
`ifdef PIC_SPECIAL_MASK_EN
    logic       smm_r = 1'b0;
`endif

    logic       int_out;
    logic [2:0] vec_idx;
    logic       vec_vld;
    logic [7:0] irr_q, isr_q;

    pic_priority_arbiter dut (
        .clk     (clk),
        .rst     (rst),
`ifdef PIC_SPECIAL_MASK_EN
        .smm     (smm_r),
`endif
        .ir      (ir_r),
        .ltim    (ltim_r),
        .imr     (imr_r),
        .aeoi    (aeoi_r),
        .eoi_stb (eoi_stb_r),
        .eoi_cmd (eoi_cmd_r),
        .eoi_lvl (eoi_lvl_r),
        .inta_p1 (p1_r),
        .inta_p2 (p2_r),
        .int_out (int_out),
        .vec_idx (vec_idx),
        .vec_vld (vec_vld),
        .irr_q   (irr_q),
        .isr_q   (isr_q)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    // Reference model state: phase 0 idle, 1 requesting, 2 between INTA pulses.
    logic [7:0] m_irr, m_isr, m_irprev;
    int         m_lp, m_phase, m_gnt;
    bit         m_spur, m_rot, m_int;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rank_of(input int i, input int lp);
        return (i - lp - 1 + 16) % 8;
    endfunction

    // Best-ranked set bit, or -1 when none.
    function automatic int best(input logic [7:0] v, input int lp);
        int b;
        b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank_of(i, lp) < rank_of(b, lp))) b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_irprev = '0;
        m_lp = 7; m_phase = 0; m_gnt = 0;
        m_spur = 0; m_rot = 0; m_int = 0;
    endtask

    task automatic model_step();
        logic [7:0] nirr, nisr, cmp;
        int nlp, cand, top;
        bit elig, nrot;
        cmp = m_isr;
`ifdef PIC_SPECIAL_MASK_EN
        if (smm_r) cmp = m_isr & ~imr_r;
`endif
        cand = best(m_irr & ~imr_r, m_lp);
        top  = best(cmp, m_lp);
        elig = (cand >= 0) && (top < 0 || rank_of(cand, m_lp) < rank_of(top, m_lp));
        for (int i = 0; i < 8; i++) begin
            if (!ir_r[i])                      nirr[i] = 1'b0;
            else if (ltim_r || !m_irprev[i])   nirr[i] = 1'b1;
            else                               nirr[i] = m_irr[i];
        end
        nisr = m_isr;
        nlp  = m_lp;
        nrot = m_rot;
        if (eoi_stb_r) begin
            case (eoi_cmd_r)
                3'b001: if (top >= 0) nisr[top] = 1'b0;
                3'b011: nisr[eoi_lvl_r] = 1'b0;
                3'b101: if (top >= 0) begin nisr[top] = 1'b0; nlp = top; end
                3'b111: if (m_isr != 0) begin nisr[eoi_lvl_r] = 1'b0; nlp = int'(eoi_lvl_r); end
                3'b110: nlp = int'(eoi_lvl_r);
                3'b100: nrot = 1;
                3'b000: nrot = 0;
                default: ;
            endcase
        end
        if (m_phase == 0) begin
            if (elig) begin m_phase = 1; m_int = 1; end
        end else if (m_phase == 1) begin
            if (p1_r) begin
                m_phase = 2;
                m_int   = 0;
                if (elig) begin
                    m_gnt = cand; m_spur = 0;
                    nisr[cand] = 1'b1;
                    nirr[cand] = 1'b0;
                end else begin
                    m_gnt = 7; m_spur = 1;
                end
            end
        end else if (p2_r) begin
            m_phase = 0;
            exp_q.push_back(m_gnt);
            if (aeoi_r && !m_spur) nisr[m_gnt] = 1'b0;
            if (aeoi_r && m_rot) nlp = m_gnt;
        end
        m_irr = nirr; m_isr = nisr; m_lp = nlp; m_rot = nrot;
        m_irprev = ir_r;
    endtask

    // Caller sets inputs at the falling edge, then one clock is applied and checked.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("int_out", 32'(int_out), 32'(m_int));
        check("irr_q", 32'(irr_q), 32'(m_irr));
        check("isr_q", 32'(isr_q), 32'(m_isr));
        @(negedge clk);
        eoi_stb_r = 1'b0;
        p1_r = 1'b0;
        p2_r = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        eoi_stb_r = 1'b1; eoi_cmd_r = cmd; eoi_lvl_r = lvl;
        step();
    endtask

    task automatic ack();
        p1_r = 1'b1; step();
        p2_r = 1'b1; step();
    endtask

    // Monitor: every vec_vld pulse consumes one expected index.
    always @(negedge clk) begin
        if (!rst && vec_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL vec_unexpected: got vec_vld=1 idx %0d expected no grant", vec_idx);
            end else begin
                check("vec_idx", 32'(vec_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst_int", 32'(int_out), 32'd0);
        check("rst_vld", 32'(vec_vld), 32'd0);
        check("rst_idx", 32'(vec_idx), 32'd0);
        check("rst_irr", 32'(irr_q), 32'd0);
        check("rst_isr", 32'(isr_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Edge mode grant of IR3.
        ir_r = 8'h08; step(); step();
        check("t1_int", 32'(int_out), 32'd1);
        p1_r = 1'b1; step();
        p2_r = 1'b1; step();
        check("t1_vld", 32'(vec_vld), 32'd1);
        check("t1_idx", 32'(vec_idx), 32'd3);
        check("t1_isr", 32'(isr_q), 32'h08);
        check("t1_irr", 32'(irr_q), 32'h00);

        // Fully nested: IR5 blocked by IR3 in service, IR1 preempts.
        ir_r = 8'h28; steps(3);
        check("t2_blocked", 32'(int_out), 32'd0);
        ir_r = 8'h2A; step(); step();
        check("t2_int", 32'(int_out), 32'd1);
        ack();
        check("t2_idx", 32'(vec_idx), 32'd1);
        check("t2_isr", 32'(isr_q), 32'h0A);
        eoi(3'b001, 3'd0);
        check("t2_eoi", 32'(isr_q), 32'h08);
        ir_r = 8'h00; step();
        eoi(3'b001, 3'd0);

        // Withdrawn request gives a spurious grant.
        ir_r = 8'h04; step(); step();
        ir_r = 8'h00; step();
        ack();
        check("t3_idx", 32'(vec_idx), 32'd7);
        check("t3_isr", 32'(isr_q), 32'h00);

        // Automatic EOI.
        aeoi_r = 1'b1;
        ir_r = 8'h40; step(); step();
        p1_r = 1'b1; step();
        check("t4_isr_set", 32'(isr_q), 32'h40);
        p2_r = 1'b1; step();
        check("t4_idx", 32'(vec_idx), 32'd6);
        check("t4_isr_clr", 32'(isr_q), 32'h00);
        aeoi_r = 1'b0; ir_r = 8'h00; step();

        // Rotate on specific EOI at level 4, then IR5 outranks IR4.
        ir_r = 8'h10; step(); step(); ack();
        ir_r = 8'h00; step();
        eoi(3'b111, 3'd4);
        ir_r = 8'h30; step(); step(); ack();
        check("t5_idx", 32'(vec_idx), 32'd5);
        ir_r = 8'h00; step();
        eoi(3'b001, 3'd0);
        eoi(3'b110, 3'd3);

        // Reset in ACK1; lp must return to 7.
        ir_r = 8'h01; step(); step();
        p1_r = 1'b1; step();
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_int", 32'(int_out), 32'd0);
        check("t6_vld", 32'(vec_vld), 32'd0);
        check("t6_isr", 32'(isr_q), 32'd0);
        check("t6_irr", 32'(irr_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        p2_r = 1'b1; step();
        check("t6_no_vld", 32'(vec_vld), 32'd0);
        ir_r = 8'h00; step();
        ir_r = 8'h11; step(); step(); ack();
        check("t6_lp7_idx", 32'(vec_idx), 32'd0);
        ir_r = 8'h00; step();
        eoi(3'b001, 3'd0);
        steps(2);

`ifdef PIC_SPECIAL_MASK_EN
        // Special mask mode: masked in-service IR0 does not block IR4.
        ir_r = 8'h01; step(); step(); ack();
        smm_r = 1'b1; imr_r = 8'h01;
        ir_r = 8'h11; step(); step(); ack();
        check("smm_idx", 32'(vec_idx), 32'd4);
        smm_r = 1'b0; imr_r = 8'h00; ir_r = 8'h00; step();
        eoi(3'b011, 3'd4);
        eoi(3'b011, 3'd0);
`endif

        // Randomized traffic.
        for (int blk = 0; blk < 12; blk++) begin
            ltim_r = 1'($urandom_range(0, 1));
            aeoi_r = 1'($urandom_range(0, 1));
`ifdef PIC_SPECIAL_MASK_EN
            smm_r = 1'($urandom_range(0, 1));
`endif
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int k;
                    k = $urandom_range(0, 7);
                    ir_r[k] = ~ir_r[k];
                end
                if ($urandom_range(0, 31) == 0)
                    imr_r = 8'($urandom & $urandom & $urandom);
                if ($urandom_range(0, 15) == 0) begin
                    eoi_stb_r = 1'b1;
                    eoi_cmd_r = 3'($urandom_range(0, 7));
                    eoi_lvl_r = 3'($urandom_range(0, 7));
                end
                if (m_phase == 1) p1_r = ($urandom_range(0, 2) == 0);
                else              p1_r = ($urandom_range(0, 63) == 0);
                if (m_phase == 2) p2_r = ($urandom_range(0, 1) == 0);
                else              p2_r = ($urandom_range(0, 63) == 0);
                step();
            end
        end

        ir_r = 8'h00;
        steps(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
